// File: rtl/smpc_periph_collect.sv
// SMPC peripheral collector: consumes the pad adapter byte stream during
// INTBACK, parses port status/ID/data records, and writes them into the
// 32-byte OREG file one page at a time. Further pages are produced by
// restarting the stream and skipping the bytes already delivered.
module smpc_periph_collect #(
  parameter int MAX_PORTS  = 2,
  parameter int PAGE_BYTES = 32,
  parameter int TIMEOUT_CE = 64
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SMPC_CE,
  input  logic       START,
  input  logic       CONTINUE,
  input  logic       BREAK,
  output logic       INPUT_ACT,
  output logic [4:0] INPUT_POS,
  input  logic [7:0] INPUT_DATA,
  input  logic       INPUT_WE,
  output logic [4:0] OREG_WA,
  output logic [7:0] OREG_WD,
  output logic       OREG_WE,
  output logic       PAGE_DONE,
  output logic       MORE,
  output logic       BUSY,
  output logic       TIMEOUT
);

  localparam int TW = $clog2(TIMEOUT_CE + 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RESTART   = 3'd1;
  localparam logic [2:0] ST_STATUS    = 3'd2;
  localparam logic [2:0] ST_ID        = 3'd3;
  localparam logic [2:0] ST_DATA      = 3'd4;
  localparam logic [2:0] ST_PAGE_WAIT = 3'd5;

  logic [2:0]    state;
  logic [3:0]    page;
  logic [7:0]    g_cnt;      // index of the next stream byte since restart
  logic [3:0]    port_cnt;
  logic [3:0]    rem;        // data bytes still owed by the current port
  logic [TW-1:0] tmo;

  // Byte counter stops at 0xFF rather than wrapping back into page 0.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [8:0] page_base;
  logic [8:0] page_end;
  logic [8:0] g_ext;
  logic [4:0] page_off;
  logic       page_full;
  logic       in_page;

  assign page_base = 9'(page) * 9'(PAGE_BYTES);
  assign page_end  = page_base + 9'(PAGE_BYTES);
  assign g_ext     = {1'b0, g_cnt};
  assign page_off  = 5'(g_ext - page_base);
  assign page_full = (g_ext == page_end);
  assign in_page   = (g_ext >= page_base) && (g_ext < page_end);

  logic [2:0] parse_next;
  logic [3:0] rem_next;
  logic       port_done;
  logic       last_port;

  // Record parser: decide where the current byte leaves the port record.
  always_comb begin
    parse_next = state;
    rem_next   = rem;
    port_done  = 1'b0;
    case (state)
      ST_STATUS: begin
        if (INPUT_DATA == 8'hF1) parse_next = ST_ID;
        else                     port_done  = 1'b1;
      end
      ST_ID: begin
        rem_next = INPUT_DATA[3:0];
        if (INPUT_DATA[3:0] == 4'd0) port_done  = 1'b1;
        else                         parse_next = ST_DATA;
      end
      ST_DATA: begin
        rem_next = rem - 4'd1;
        if (rem == 4'd1) port_done = 1'b1;
      end
      default: ;
    endcase
    if (port_done) parse_next = ST_STATUS;
    last_port = port_done && ((port_cnt + 4'd1) == 4'(MAX_PORTS));
  end

  assign BUSY = (state != ST_IDLE) && (state != ST_PAGE_WAIT);

  // Main sequencer: stream control, page slicing, OREG writes and pulses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      page      <= 4'd0;
      g_cnt     <= 8'd0;
      port_cnt  <= 4'd0;
      rem       <= 4'd0;
      tmo       <= '0;
      INPUT_ACT <= 1'b0;
      INPUT_POS <= 5'd0;
      OREG_WA   <= 5'd0;
      OREG_WD   <= 8'd0;
      OREG_WE   <= 1'b0;
      PAGE_DONE <= 1'b0;
      MORE      <= 1'b0;
      TIMEOUT   <= 1'b0;
    end else begin
      OREG_WE <= 1'b0;
      if (SMPC_CE) begin
        PAGE_DONE <= 1'b0;
        MORE      <= 1'b0;
        TIMEOUT   <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (START) begin
              state     <= ST_RESTART;
              page      <= 4'd0;
              INPUT_ACT <= 1'b0;
            end
          end
          ST_RESTART: begin
            g_cnt     <= 8'd0;
            port_cnt  <= 4'd0;
            tmo       <= '0;
            INPUT_ACT <= 1'b1;
            state     <= ST_STATUS;
          end
          ST_STATUS, ST_ID, ST_DATA: begin
            if (INPUT_WE) begin
              g_cnt <= sat_inc8(g_cnt);
              tmo   <= '0;
              rem   <= rem_next;
              if (port_done) port_cnt <= port_cnt + 4'd1;
              if (page_full) begin
                // The byte that would overflow the page is left for the next one.
                INPUT_ACT <= 1'b0;
                PAGE_DONE <= 1'b1;
                MORE      <= 1'b1;
                state     <= ST_PAGE_WAIT;
              end else begin
                if (in_page) begin
                  OREG_WE   <= 1'b1;
                  OREG_WA   <= page_off;
                  INPUT_POS <= page_off;
                  OREG_WD   <= INPUT_DATA;
                end
                if (last_port) begin
                  INPUT_ACT <= 1'b0;
                  PAGE_DONE <= 1'b1;
                  MORE      <= 1'b0;
                  state     <= ST_IDLE;
                end else begin
                  state <= parse_next;
                end
              end
            end else if (tmo == TW'(TIMEOUT_CE - 1)) begin
              INPUT_ACT <= 1'b0;
              TIMEOUT   <= 1'b1;
              PAGE_DONE <= 1'b1;
              MORE      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              tmo <= tmo + TW'(1);
            end
          end
          ST_PAGE_WAIT: begin
            if (BREAK) begin
              PAGE_DONE <= 1'b1;
              MORE      <= 1'b0;
              state     <= ST_IDLE;
            end else if (START) begin
              page  <= 4'd0;
              state <= ST_RESTART;
            end else if (CONTINUE) begin
              page  <= page + 4'd1;
              state <= ST_RESTART;
            end
          end
          default: begin
            INPUT_ACT <= 1'b0;
            state     <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_smpc_periph_collect.sv
// Bench for smpc_periph_collect: a pad-adapter stream model feeds two DUT
// instances (MAX_PORTS=2 and MAX_PORTS=4); an OREG mirror captures writes.
module tb_smpc_periph_collect;

  logic       CLK;
  logic       RST_N;
  logic       SMPC_CE;
  logic       START;
  logic       CONTINUE;
  logic       BREAK;
  logic [7:0] INPUT_DATA;
  logic       INPUT_WE;
  logic       sel;

  logic       d_act  [2];
  logic [4:0] d_pos  [2];
  logic [4:0] d_wa   [2];
  logic [7:0] d_wd   [2];
  logic       d_we   [2];
  logic       d_pd   [2];
  logic       d_more [2];
  logic       d_busy [2];
  logic       d_to   [2];
  logic       start_g[2];

  assign start_g[0] = START & ~sel;
  assign start_g[1] = START & sel;

  smpc_periph_collect #(.MAX_PORTS(2), .PAGE_BYTES(32), .TIMEOUT_CE(64)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .SMPC_CE(SMPC_CE), .START(start_g[0]),
    .CONTINUE(CONTINUE), .BREAK(BREAK), .INPUT_ACT(d_act[0]), .INPUT_POS(d_pos[0]),
    .INPUT_DATA(INPUT_DATA), .INPUT_WE(INPUT_WE), .OREG_WA(d_wa[0]), .OREG_WD(d_wd[0]),
    .OREG_WE(d_we[0]), .PAGE_DONE(d_pd[0]), .MORE(d_more[0]), .BUSY(d_busy[0]),
    .TIMEOUT(d_to[0]));

  smpc_periph_collect #(.MAX_PORTS(4), .PAGE_BYTES(32), .TIMEOUT_CE(64)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N), .SMPC_CE(SMPC_CE), .START(start_g[1]),
    .CONTINUE(CONTINUE), .BREAK(BREAK), .INPUT_ACT(d_act[1]), .INPUT_POS(d_pos[1]),
    .INPUT_DATA(INPUT_DATA), .INPUT_WE(INPUT_WE), .OREG_WA(d_wa[1]), .OREG_WD(d_wd[1]),
    .OREG_WE(d_we[1]), .PAGE_DONE(d_pd[1]), .MORE(d_more[1]), .BUSY(d_busy[1]),
    .TIMEOUT(d_to[1]));

  logic       m_act, m_we, m_pd, m_more, m_busy, m_to;
  logic [4:0] m_pos, m_wa;
  logic [7:0] m_wd;
  assign m_act  = d_act[sel];
  assign m_pos  = d_pos[sel];
  assign m_wa   = d_wa[sel];
  assign m_wd   = d_wd[sel];
  assign m_we   = d_we[sel];
  assign m_pd   = d_pd[sel];
  assign m_more = d_more[sel];
  assign m_busy = d_busy[sel];
  assign m_to   = d_to[sel];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk;
  int n_fail;

  logic [7:0] stream [64];
  int         src_len;
  int         src_idx;

  logic [7:0] oreg_m [32];
  int wr_cnt, pd_cnt, to_cnt, cyc, wr_cyc, pd_cyc, to_cyc, pos_bad;
  logic pd_more;

  typedef struct {
    logic         sel;
    int           len;
    logic [127:0] stim;
    int           exp_wr;
    logic [127:0] exp_oreg;
  } vec_t;
  vec_t vecs [5];

  // Pad adapter model: restarts from byte 0 whenever INPUT_ACT is low.
  initial begin
    src_idx    = 0;
    INPUT_WE   = 1'b0;
    INPUT_DATA = 8'h00;
    forever begin
      @(posedge CLK);
      if (INPUT_WE) src_idx++;
      #1;
      if (!m_act) begin
        src_idx  = 0;
        INPUT_WE = 1'b0;
      end else if (src_idx < src_len) begin
        INPUT_WE   = 1'b1;
        INPUT_DATA = stream[src_idx];
      end else begin
        INPUT_WE = 1'b0;
      end
    end
  end

  // Output monitor: OREG mirror and pulse bookkeeping.
  always @(negedge CLK) begin
    cyc++;
    if (m_we) begin
      oreg_m[m_wa] = m_wd;
      wr_cnt++;
      wr_cyc = cyc;
      if (m_pos !== m_wa) pos_bad++;
    end
    if (m_pd) begin
      pd_cnt++;
      pd_more = m_more;
      pd_cyc  = cyc;
    end
    if (m_to) begin
      to_cnt++;
      to_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 32; i++) oreg_m[i] = 8'hEE;
    wr_cnt = 0; pd_cnt = 0; to_cnt = 0; pd_more = 1'bx;
  endtask

  task automatic pulse(input int which);
    @(posedge CLK); #1;
    case (which)
      0: START = 1'b1;
      1: CONTINUE = 1'b1;
      default: BREAK = 1'b1;
    endcase
    @(posedge CLK); #1;
    START = 1'b0; CONTINUE = 1'b0; BREAK = 1'b0;
  endtask

  task automatic wait_pd(input string name);
    int n;
    n = 0;
    while (pd_cnt == 0 && n < 300) begin
      @(posedge CLK); #2;
      n++;
    end
    chk({name, " page_done seen"}, 32'(pd_cnt != 0), 32'd1);
  endtask

  task automatic wait_wr(input int cnt, input string name);
    int n;
    n = 0;
    while (wr_cnt < cnt && n < 300) begin
      @(posedge CLK); #2;
      n++;
    end
    chk({name, " writes reached"}, 32'(wr_cnt >= cnt), 32'd1);
  endtask

  task automatic run_vec(input int vi);
    sel = vecs[vi].sel;
    src_len = vecs[vi].len;
    for (int i = 0; i < vecs[vi].len; i++) stream[i] = vecs[vi].stim[127-8*i -: 8];
    clear_mon();
    pulse(0);
    wait_pd($sformatf("vec%0d", vi));
    repeat (3) @(posedge CLK);
    #2;
    chk($sformatf("vec%0d write count", vi), 32'(wr_cnt), 32'(vecs[vi].exp_wr));
    chk($sformatf("vec%0d page_done count", vi), 32'(pd_cnt), 32'd1);
    chk($sformatf("vec%0d more", vi), 32'(pd_more), 32'd0);
    chk($sformatf("vec%0d input_act", vi), 32'(m_act), 32'd0);
    chk($sformatf("vec%0d busy", vi), 32'(m_busy), 32'd0);
    for (int i = 0; i < vecs[vi].exp_wr; i++)
      chk($sformatf("vec%0d oreg[%0d]", vi, i), 32'(oreg_m[i]), 32'(vecs[vi].exp_oreg[127-8*i -: 8]));
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, " input_act"}, 32'(m_act), 32'd0);
    chk({name, " input_pos"}, 32'(m_pos), 32'd0);
    chk({name, " oreg_wa"}, 32'(m_wa), 32'd0);
    chk({name, " oreg_wd"}, 32'(m_wd), 32'd0);
    chk({name, " oreg_we"}, 32'(m_we), 32'd0);
    chk({name, " page_done"}, 32'(d_pd[0] | d_pd[1]), 32'd0);
    chk({name, " more"}, 32'(m_more), 32'd0);
    chk({name, " busy"}, 32'(m_busy), 32'd0);
    chk({name, " timeout"}, 32'(m_to), 32'd0);
  endtask

  // Two-page delivery on the MAX_PORTS=4 instance; stream must be loaded.
  task automatic run_two_pages(input string name, input int len, input int start_mid);
    sel = 1'b1;
    src_len = len;
    clear_mon();
    pd_more = 1'b0;
    pulse(0);
    if (start_mid != 0) begin
      wait_wr(10, {name, " mid"});
      pulse(0);
    end
    wait_pd({name, " p0"});
    repeat (2) @(posedge CLK);
    #2;
    chk({name, " p0 writes"}, 32'(wr_cnt), 32'd32);
    chk({name, " p0 more"}, 32'(pd_more), 32'd1);
    chk({name, " p0 busy"}, 32'(m_busy), 32'd0);
    chk({name, " p0 input_act"}, 32'(m_act), 32'd0);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s p0 oreg[%0d]", name, i), 32'(oreg_m[i]), 32'(stream[i]));
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    cyc = 0; pos_bad = 0; wr_cyc = 0; pd_cyc = 0; to_cyc = 0;
    RST_N = 1'b0; SMPC_CE = 1'b1; START = 1'b0; CONTINUE = 1'b0; BREAK = 1'b0;
    sel = 1'b0; src_len = 0;
    clear_mon();

    vecs[0] = '{sel: 1'b0, len: 8, stim: {64'hF1021234F102ABCD, 64'h0}, exp_wr: 8,
                exp_oreg: {64'hF1021234F102ABCD, 64'h0}};
    vecs[1] = '{sel: 1'b0, len: 9, stim: {72'hF0F116555555555555, 56'h0}, exp_wr: 9,
                exp_oreg: {72'hF0F116555555555555, 56'h0}};
    vecs[2] = '{sel: 1'b0, len: 3, stim: {24'hF110F0, 104'h0}, exp_wr: 3,
                exp_oreg: {24'hF110F0, 104'h0}};
    vecs[3] = '{sel: 1'b1, len: 4, stim: {32'hF0F0F0F0, 96'h0}, exp_wr: 4,
                exp_oreg: {32'hF0F0F0F0, 96'h0}};
    vecs[4] = '{sel: 1'b0, len: 3, stim: {24'hF0F0AA, 104'h0}, exp_wr: 2,
                exp_oreg: {16'hF0F0, 112'h0}};

    repeat (3) @(posedge CLK);
    #2;
    chk_idle_outputs("reset held");
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    chk_idle_outputs("after reset");

    for (int v = 0; v < 5; v++) run_vec(v);

    // Four 11-byte records: page 0 full, START mid-run ignored, CONTINUE for page 1.
    for (int p = 0; p < 4; p++) begin
      stream[11*p]     = 8'hF1;
      stream[11*p + 1] = 8'h19;
      for (int k = 0; k < 9; k++) stream[11*p + 2 + k] = 8'(8'h20 + 16*p + k);
    end
    run_two_pages("dm", 44, 1);
    clear_mon();
    pulse(1);
    #1;
    chk("dm restart input_act low", 32'(m_act), 32'd0);
    chk("dm restart busy", 32'(m_busy), 32'd1);
    @(posedge CLK); #2;
    chk("dm restart input_act high", 32'(m_act), 32'd1);
    wait_pd("dm p1");
    repeat (2) @(posedge CLK);
    #2;
    chk("dm p1 writes", 32'(wr_cnt), 32'd12);
    chk("dm p1 more", 32'(pd_more), 32'd0);
    chk("dm p1 input_act", 32'(m_act), 32'd0);
    for (int i = 0; i < 12; i++)
      chk($sformatf("dm p1 oreg[%0d]", i), 32'(oreg_m[i]), 32'(stream[32+i]));

    // Same stream, BREAK in PAGE_WAIT, then a stray CONTINUE.
    run_two_pages("brk", 44, 0);
    clear_mon();
    pd_more = 1'b1;
    pulse(2);
    repeat (3) @(posedge CLK);
    #2;
    chk("brk page_done", 32'(pd_cnt), 32'd1);
    chk("brk more", 32'(pd_more), 32'd0);
    chk("brk writes", 32'(wr_cnt), 32'd0);
    chk("brk busy", 32'(m_busy), 32'd0);
    clear_mon();
    pulse(1);
    repeat (20) @(posedge CLK);
    #2;
    chk("brk continue writes", 32'(wr_cnt), 32'd0);
    chk("brk continue page_done", 32'(pd_cnt), 32'd0);
    chk("brk continue input_act", 32'(m_act), 32'd0);

    // Final byte lands exactly on the page boundary: page full wins.
    stream[0] = 8'hF1; stream[1] = 8'h0F;
    for (int k = 0; k < 15; k++) stream[2+k] = 8'(8'h60 + k);
    stream[17] = 8'hF1; stream[18] = 8'h0C;
    for (int k = 0; k < 12; k++) stream[19+k] = 8'(8'h80 + k);
    stream[31] = 8'hF0; stream[32] = 8'hF0;
    run_two_pages("edge", 33, 0);
    clear_mon();
    pulse(1);
    wait_pd("edge p1");
    repeat (2) @(posedge CLK);
    #2;
    chk("edge p1 writes", 32'(wr_cnt), 32'd1);
    chk("edge p1 oreg[0]", 32'(oreg_m[0]), 32'hF0);
    chk("edge p1 more", 32'(pd_more), 32'd0);

    // Source stalls after the status byte.
    sel = 1'b0;
    stream[0] = 8'hF1;
    src_len = 1;
    clear_mon();
    pulse(0);
    begin
      int n;
      n = 0;
      while (to_cnt == 0 && n < 300) begin
        @(posedge CLK); #2;
        n++;
      end
    end
    chk("tmo seen", 32'(to_cnt), 32'd1);
    chk("tmo status written", 32'(wr_cnt), 32'd1);
    chk("tmo latency", 32'(to_cyc - wr_cyc), 32'd64);
    chk("tmo page_done same cycle", 32'(pd_cyc - to_cyc), 32'd0);
    chk("tmo page_done count", 32'(pd_cnt), 32'd1);
    chk("tmo more", 32'(pd_more), 32'd0);
    chk("tmo input_act", 32'(m_act), 32'd0);
    chk("tmo busy", 32'(m_busy), 32'd0);

    // Reset asserted while the first pad's data bytes are being written.
    sel = 1'b0;
    src_len = 8;
    for (int i = 0; i < 8; i++) stream[i] = vecs[0].stim[127-8*i -: 8];
    clear_mon();
    pulse(0);
    wait_wr(2, "rst");
    chk("rst busy before", 32'(m_busy), 32'd1);
    RST_N = 1'b0;
    #1;
    chk_idle_outputs("rst async");
    begin
      int w;
      w = wr_cnt;
      repeat (3) @(posedge CLK);
      #2;
      RST_N = 1'b1;
      repeat (5) @(posedge CLK);
      #2;
      chk("rst no further writes", 32'(wr_cnt), 32'(w));
      chk("rst idle after release", 32'(m_busy), 32'd0);
    end
    run_vec(0);

    chk("input_pos tracks oreg_wa", 32'(pos_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
